uart_baud_gen: RTL and testbench

//  Parametrised fractional baud-rate generator for the UART peripheral.

---
 rtl/uart_baud_gen_if.sv | 22 ++
 rtl/uart_baud_gen.sv | 60 ++++++
 tb/tb_uart_baud_gen.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/uart_baud_gen_if.sv
// uart_baud_gen_if: divisor/enable/resync controls into the baud generator and its strobes back out
interface uart_baud_gen_if #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
);
    logic              en;
    logic              div_wr;
    logic [DIV_W-1:0]  div_int_i;
    logic [FRAC_W-1:0] div_frac_i;
    logic              rx_resync;
    logic              os_tick;
    logic              tx_tick;
    logic              rx_sample;
    modport master (
        output en, div_wr, div_int_i, div_frac_i, rx_resync,
        input  os_tick, tx_tick, rx_sample
    );
    modport slave (
        input  en, div_wr, div_int_i, div_frac_i, rx_resync,
        output os_tick, tx_tick, rx_sample
    );
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: fractional baud generator producing oversample, TX bit and RX mid-bit strobes
module uart_baud_gen #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4,
    parameter int OVS    = 16
) (
    input logic            clk,
    input logic            rst_n,
    uart_baud_gen_if.slave bus
);
    localparam int PH_W = $clog2(OVS);
    logic [DIV_W-1:0]  div_int, cnt, n;
    logic [FRAC_W-1:0] div_frac, frac_acc;
    logic [FRAC_W:0]   frac_sum;
    logic [DIV_W:0]    last;
    logic [PH_W-1:0]   tx_ph, rx_ph;
    logic              fire, os_tick_r, tx_tick_r, rx_sample_r;
    // The fractional carry stretches the current period by one cycle.
    always_comb begin
        n        = (div_int == '0) ? DIV_W'(1) : div_int;
        frac_sum = {1'b0, frac_acc} + {1'b0, div_frac};
        last     = {1'b0, n} - (DIV_W+1)'(1) + (DIV_W+1)'(frac_sum[FRAC_W]);
        fire     = bus.en && !bus.div_wr && ({1'b0, cnt} == last);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_int     <= DIV_W'(1);
            div_frac    <= '0;
            cnt         <= '0;
            frac_acc    <= '0;
            tx_ph       <= '0;
            rx_ph       <= '0;
            os_tick_r   <= 1'b0;
            tx_tick_r   <= 1'b0;
            rx_sample_r <= 1'b0;
        end else begin
            if (bus.div_wr) begin
                div_int  <= bus.div_int_i;
                div_frac <= bus.div_frac_i;
            end
            os_tick_r   <= fire;
            tx_tick_r   <= fire && tx_ph == PH_W'(OVS-1);
            rx_sample_r <= fire && !bus.rx_resync && rx_ph == PH_W'(OVS/2-1);
            if (bus.div_wr || !bus.en) begin
                cnt      <= '0;
                frac_acc <= '0;
                tx_ph    <= '0;
                rx_ph    <= '0;
            end else begin
                cnt      <= fire ? '0 : cnt + DIV_W'(1);
                frac_acc <= fire ? frac_sum[FRAC_W-1:0] : frac_acc;
                tx_ph    <= tx_ph + PH_W'(fire);
                rx_ph    <= bus.rx_resync ? PH_W'(fire) : rx_ph + PH_W'(fire);
            end
        end
    end
    assign bus.os_tick   = os_tick_r;
    assign bus.tx_tick   = tx_tick_r;
    assign bus.rx_sample = rx_sample_r;
endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: random divisor/enable/resync segments; expected strobe edges come from closed-form tick times
module tb_uart_baud_gen;
    localparam int DIV_W = 16, FRAC_W = 4, OVS = 16;
    logic clk = 1'b0, rst_n = 1'b0;
    int edge_n = 0, total = 0, bad = 0;
    int shd_n = 1, shd_f = 0;
    int exp_q[3][$];
    bit en_on = 1'b0;
    string nm[3] = '{"os_tick", "tx_tick", "rx_sample"};

    uart_baud_gen_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) bus();
    uart_baud_gen #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS(OVS)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    // Each strobe seen, and each expected strobe that is due, is one comparison.
    always @(negedge clk) begin
        logic [2:0] st;
        bit due;
        if (rst_n) begin
            st = {bus.rx_sample, bus.tx_tick, bus.os_tick};
            for (int i = 0; i < 3; i++) begin
                due = exp_q[i].size() != 0 && exp_q[i][0] == edge_n;
                if (st[i] || due) begin
                    total++;
                    if (st[i] != due) begin
                        bad++;
                        $display("FAIL %s at edge %0d: got %0b expected %0b", nm[i], edge_n, st[i], due);
                    end
                    if (due) void'(exp_q[i].pop_front());
                end
            end
        end
    end

    task automatic chk(string n, int got, int exp_v);
        total++;
        if (got != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", n, got, exp_v);
        end
    endtask

    // Edge after which tick j is visible: j periods of N plus the accumulated fractional carries.
    function automatic int tt(int s, int j);
        return s + j * shd_n + (j * shd_f) / (1 << FRAC_W) - 1;
    endfunction

    task automatic plan(int s, int stop, int rs[$]);
        int t, r, j0;
        for (int j = 1; tt(s, j) < stop; j++) begin
            t = tt(s, j);
            r = -1;
            foreach (rs[k]) if (rs[k] <= t) r = rs[k];
            j0 = 0;
            if (r >= 0) while (tt(s, j0 + 1) < r) j0++;
            exp_q[0].push_back(t);
            if (j % OVS == 0) exp_q[1].push_back(t);
            if ((j - j0) % OVS == OVS / 2) exp_q[2].push_back(t);
        end
    endtask

    // kind 0: write divisor with en=1; kind 1: en low; kind 2: raise en, no write
    task automatic seg(int kind, int d_int, int d_frac, int len, int rs_pct);
        int e, s;
        int rs_e[$];
        @(negedge clk);
        e = edge_n + 1;
        bus.rx_resync = 1'b0;
        bus.div_wr = (kind == 0);
        bus.en = (kind != 1);
        en_on = (kind != 1);
        bus.div_int_i = (kind == 0) ? DIV_W'(d_int) : DIV_W'($urandom);
        bus.div_frac_i = (kind == 0) ? FRAC_W'(d_frac) : FRAC_W'($urandom);
        if (kind == 0) begin
            shd_n = (d_int < 1) ? 1 : d_int;
            shd_f = d_frac;
        end
        s = (kind == 0) ? e + 1 : e;
        for (int i = 1; i <= len; i++)
            if (kind != 1 && $urandom_range(99) < rs_pct) rs_e.push_back(e + i);
        if (kind != 1) plan(s, e + len + 1, rs_e);
        for (int i = 1; i <= len; i++) begin
            @(negedge clk);
            bus.div_wr = 1'b0;
            bus.rx_resync = rs_e.size() != 0 && rs_e[0] == e + i;
            if (bus.rx_resync) void'(rs_e.pop_front());
            bus.div_int_i = DIV_W'($urandom);
            bus.div_frac_i = FRAC_W'($urandom);
        end
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2;
        chk("pre_rst_os", int'(bus.os_tick), 1);
        rst_n = 1'b0;
        bus.en = 1'b0;
        bus.div_wr = 1'b0;
        bus.rx_resync = 1'b0;
        en_on = 1'b0;
        #1;
        chk("rst_os", int'(bus.os_tick), 0);
        chk("rst_tx", int'(bus.tx_tick), 0);
        chk("rst_rx", int'(bus.rx_sample), 0);
        for (int i = 0; i < 3; i++) exp_q[i].delete();
        shd_n = 1;
        shd_f = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int k;
        bus.en = 1'b0;
        bus.div_wr = 1'b0;
        bus.div_int_i = '0;
        bus.div_frac_i = '0;
        bus.rx_resync = 1'b0;
        repeat (3) @(negedge clk);
        chk("init_os", int'(bus.os_tick), 0);
        chk("init_tx", int'(bus.tx_tick), 0);
        chk("init_rx", int'(bus.rx_sample), 0);
        rst_n = 1'b1;
        seg(1, 0, 0, 3, 0);
        seg(0, 4, 0, 140, 0);
        seg(0, 4, 8, 160, 0);
        seg(0, 10, 0, 7, 0);
        seg(0, 3, 0, 60, 0);
        seg(0, 2, 0, 220, 3);
        seg(0, 0, 0, 40, 2);
        seg(1, 0, 0, 10, 0);
        seg(2, 0, 0, 40, 0);
        for (int n = 0; n < 16; n++) begin
            k = en_on ? ($urandom_range(1) ? 0 : 1) : ($urandom_range(1) ? 0 : 2);
            seg(k, ($urandom_range(5) == 0) ? $urandom_range(40) : $urandom_range(7),
                $urandom_range(15), $urandom_range(200, 20), $urandom_range(4));
        end
        seg(0, 0, 0, 20, 0);
        mid_reset();
        seg(2, 0, 0, 30, 0);
        seg(1, 0, 0, 4, 0);
        for (int i = 0; i < 3; i++) chk({nm[i], "_leftover"}, exp_q[i].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
